// File: rtl/oloca_pkg.sv
// Shared constants for the OLOCA error-metric engine.
// FSM encodings, default adder geometry and the ED width helper.
package oloca_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned OLOCA_N = 16;
  localparam int unsigned OLOCA_K = 8;
  localparam int unsigned OLOCA_C = 4;

  function automatic int unsigned ed_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/oloca_adder.sv
// OLOCA approximate adder: constant-1 LSBs, OR-ed lower part,
// exact upper part with zero carry-in.
module oloca_adder #(
  parameter int N = 16,
  parameter int K = 8,
  parameter int C = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N-K:0] hi;
  logic [K-1:0] lo;

  assign hi = {1'b0, a_i[N-1:K]} + {1'b0, b_i[N-1:K]};

  always_comb begin
    lo = '0;
    for (int i = 0; i < K; i++) begin
      lo[i] = (i < C) ? 1'b1 : (a_i[i] | b_i[i]);
    end
  end

  assign sum_o   = {hi[N-K-1:0], lo};
  assign carry_o = hi[N-K];

endmodule

// File: rtl/oloca_err_monitor.sv
// Streaming error-metric engine comparing OLOCA against an exact adder.
// Accept -> result regs -> ED and accumulator update, no stalls.
module oloca_err_monitor
  import oloca_pkg::*;
#(
  parameter int N             = OLOCA_N,
  parameter int K             = OLOCA_K,
  parameter int C             = OLOCA_C,
  parameter int CNT_W         = 32,
  parameter int INCLUDE_CARRY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [N-1:0]         in_b,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     zero_cnt,
  output logic [CNT_W+N:0]     sum_ed,
  output logic [N:0]           max_ed
);

  localparam int EW = int'(ed_width(N));
  localparam int SW = CNT_W + N + 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_q, num_q;
  logic             start_ok, accept, last;

  logic [N-1:0]     ap_sum;
  logic             ap_cy;
  logic [EW-1:0]    ex_d, ap_d;
  logic             v1_q;
  logic [EW-1:0]    ex1_q, ap1_q;

  logic [EW-1:0]    ed;
  logic [SW:0]      sum_nx;
  logic [CNT_W-1:0] smp_q, err_q, zero_q;
  logic [SW-1:0]    sum_q;
  logic [EW-1:0]    max_q;

  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign in_ready = (state_q == ST_RUN) & (acc_q < num_q);
  assign accept   = in_valid & in_ready;
  assign last     = (acc_q + 1'b1) == num_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start)
          state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (accept && last) state_d = ST_DRAIN;
      end
      // S1 holds the final pair and retires on this edge
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      num_q   <= '0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        acc_q <= '0;
        num_q <= num_samples;
      end else if (accept) begin
        acc_q <= acc_q + 1'b1;
      end
    end
  end

  oloca_adder #(.N(N), .K(K), .C(C)) u_adder (
    .a_i     (in_a),
    .b_i     (in_b),
    .sum_o   (ap_sum),
    .carry_o (ap_cy)
  );

  always_comb begin
    ex_d = {1'b0, in_a} + {1'b0, in_b};
    ap_d = {ap_cy, ap_sum};
    if (INCLUDE_CARRY == 0) begin
      ex_d[N] = 1'b0;
      ap_d[N] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      ex1_q <= '0;
      ap1_q <= '0;
    end else begin
      v1_q  <= accept & ~clear;
      ex1_q <= ex_d;
      ap1_q <= ap_d;
    end
  end

  assign ed     = (ap1_q >= ex1_q) ? (ap1_q - ex1_q) : (ex1_q - ap1_q);
  assign sum_nx = {1'b0, sum_q} + {{(SW + 1 - EW){1'b0}}, ed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      err_q  <= '0;
      zero_q <= '0;
      sum_q  <= '0;
      max_q  <= '0;
    end else if (clear || start_ok) begin
      smp_q  <= '0;
      err_q  <= '0;
      zero_q <= '0;
      sum_q  <= '0;
      max_q  <= '0;
    end else if (v1_q) begin
      smp_q <= smp_q + 1'b1;
      if (ed != '0)     err_q  <= err_q + 1'b1;
      if (ex1_q == '0)  zero_q <= zero_q + 1'b1;
      if (ed > max_q)   max_q  <= ed;
      sum_q <= sum_nx[SW] ? {SW{1'b1}} : sum_nx[SW-1:0];
    end
  end

  assign busy       = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign sample_cnt = smp_q;
  assign err_cnt    = err_q;
  assign zero_cnt   = zero_q;
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;

endmodule

// File: tb/tb_oloca_err_monitor.sv
// Directed bench for oloca_err_monitor (N=16,K=8,C=4, sum-only ED).
// Checks are immediate assertions against hand-computed values.
module tb_oloca_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        busy, done;
  logic [31:0] sample_cnt, err_cnt, zero_cnt;
  logic [48:0] sum_ed;
  logic [16:0] max_ed;

  int n_chk = 0;
  int n_err = 0;

  oloca_err_monitor #(
    .N(16), .K(8), .C(4), .CNT_W(32), .INCLUDE_CARRY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .zero_cnt(zero_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", {63'b0, done}, 64'd1);
  endtask

  task automatic chk_all(input string tag, input longint s, input longint e,
                         input longint z, input longint se, input longint mx);
    chk({tag, "_sample"}, sample_cnt, s);
    chk({tag, "_err"},    err_cnt,    e);
    chk({tag, "_zero"},   zero_cnt,   z);
    chk({tag, "_sum"},    sum_ed,     se);
    chk({tag, "_max"},    max_ed,     mx);
  endtask

  function automatic logic [16:0] ref_approx(input logic [15:0] a,
                                             input logic [15:0] b);
    logic [16:0] r;
    r = ({9'b0, a[15:8]} + {9'b0, b[15:8]}) << 8;
    r[7:4] = a[7:4] | b[7:4];
    r[3:0] = 4'hF;
    return r;
  endfunction

  longint m_s, m_e, m_z, m_sum, m_max;
  logic [15:0] ra, rb, ex16, ap16;
  logic [16:0] ex17;
  longint ed;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_busy",  {63'b0, busy},     64'd0);
    chk("rst_done",  {63'b0, done},     64'd0);
    chk_all("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero operands, approx 0x000F
    do_start(1);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    send(16'h0000, 16'h0000);
    wait_done();
    chk_all("t1", 1, 1, 1, 15, 15);

    // 2: carry out of the lower part is lost
    do_start(1);
    send(16'h00FF, 16'h0001);
    wait_done();
    chk_all("t2", 1, 1, 0, 1, 1);

    // 3: disjoint lower bits, exact match
    do_start(1);
    send(16'h000F, 16'h00F0);
    wait_done();
    chk_all("t3", 1, 0, 0, 0, 0);

    // 4: in_valid toggling, 4 samples of 1+2 (ED 12 each)
    do_start(4);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 16'h0001;
      in_b = 16'h0002;
      if (i == 7) begin
        chk("t4_ready_low", {63'b0, in_ready}, 64'd0);
        chk("t4_drain_done", {63'b0, done}, 64'd0);
        chk("t4_drain_busy", {63'b0, busy}, 64'd1);
      end
      if (i == 8) chk("t4_done_lat", {63'b0, done}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk_all("t4", 4, 4, 0, 48, 12);

    // 5: async reset mid-run, then fresh 3-sample run
    do_start(5);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'b0, busy}, 64'd0);
    chk_all("t5_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(3);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    wait_done();
    chk_all("t5", 3, 3, 3, 45, 15);

    // clear with a pair in flight discards it and idles
    do_start(3);
    in_a = 16'h0000;
    in_b = 16'h0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("clr_busy",  {63'b0, busy},     64'd0);
    chk("clr_done",  {63'b0, done},     64'd0);
    chk("clr_ready", {63'b0, in_ready}, 64'd0);
    chk_all("clr", 0, 0, 0, 0, 0);

    // 6: random pairs against a reference model
    m_s = 0; m_e = 0; m_z = 0; m_sum = 0; m_max = 0;
    do_start(300);
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i % 7 == 0) rb = (~ra) + 16'd1;
      if (i % 11 == 0) ra = 16'hFFFF;
      ex17 = {1'b0, ra} + {1'b0, rb};
      ex16 = ex17[15:0];
      ap16 = ref_approx(ra, rb)[15:0];
      ed = (ap16 > ex16) ? longint'(ap16 - ex16) : longint'(ex16 - ap16);
      m_s++;
      if (ed != 0) m_e++;
      if (ex16 == 16'h0) m_z++;
      m_sum += ed;
      if (ed > m_max) m_max = ed;
      send(ra, rb);
    end
    wait_done();
    chk_all("t6", m_s, m_e, m_z, m_sum, m_max);

    // zero-sample run completes on the next cycle with cleared metrics
    do_start(0);
    chk("t6_zero_done", {63'b0, done}, 64'd1);
    chk("t6_zero_busy", {63'b0, busy}, 64'd0);
    chk_all("t6z", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
